alu_thread_sched: RTL and testbench
===================================

// Module: alu_thread_sched
// PURPOSE
//  Issue scheduler sharing the single-cycle ALU between NTHREADS hardware threads.
//  Round-robin picks one eligible thread per cycle and drives the ALU issue slot with that thread's id.
//  Blocks a thread after it issues a branch/jump until the ALU returns its new_pc (thread_exu_id_out).
//  Sits between the per-thread decode stages and the ALU.
// PARAMETERS
//  NTHREADS   4   hardware threads; power of 2, >=2
//  TID_W      2   thread id width, $clog2(NTHREADS)
//  BLK_TMO    15  max cycles a thread may stay BLOCKED before sched_err; 0 disables the check
// PORTS
//  clk               in   1         clock
//  rst               in   1         synchronous, active-high reset
//  thread_en         in   NTHREADS  config: thread may be scheduled
//  req_valid         in   NTHREADS  thread t has a decoded instruction
//  req_ctrl_flow     in   NTHREADS  request is branch/jal/jalr
//  req_ready         out  NTHREADS  one-hot grant; handshake = req_valid & req_ready
//  issue_valid       out  1         ALU issue slot occupied (registered)
//  issue_tid         out  TID_W     thread id driven to ALU thread_exu_id
//  done_valid        in   1         ALU returned new_pc for a control-flow op
//  done_tid          in   TID_W     thread id of that result
//  flush             in   1         unblock all threads, drop this cycle's grant
//  blocked           out  NTHREADS  per-thread BLOCKED state (registered)
//  sched_err         out  1         sticky: spurious done or block timeout
// BEHAVIOUR
//  - Reset: req_ready=0, issue_valid=0, issue_tid=0, blocked=0, sched_err=0.
//    RR pointer last_tid=NTHREADS-1, so thread 0 has top priority first.
//  - Eligible(t) = thread_en[t] & req_valid[t] & ~blocked[t].
//  - req_ready is combinational, at most one bit set.
//    It goes to the first eligible thread searching from last_tid+1, mod NTHREADS.
//    req_ready is 0 whenever flush or rst is high.
//  - On a grant of t: next cycle issue_valid=1, issue_tid=t (issue latency 1).
//    last_tid<=t. With no grant: issue_valid<=0 and last_tid holds.
//  - Per-thread FSM RUN/BLOCKED:
//    RUN->BLOCKED on a grant with req_ctrl_flow[t]=1.
//    BLOCKED->RUN on done_valid & done_tid==t, or on flush.
//    Both transitions take effect the following cycle, so the earliest re-grant is the cycle after done.
//  - Minimum turnaround for a control-flow thread is 3 cycles:
//    grant, ALU issue, done/new_pc, then re-grant.
//  - done_valid for a thread in RUN: ignored for state; sets sched_err.
//  - Timeout: per-thread counter (width $clog2(BLK_TMO+1)) counts cycles in BLOCKED and saturates.
//    Reaching BLK_TMO sets sched_err; the thread stays BLOCKED until done or flush.
//  - thread_en deasserted while BLOCKED: thread stays BLOCKED; done still unblocks it.
//  - flush together with done: flush wins (all RUN), no sched_err for that done.
//  - Reset mid-operation clears everything on the same edge; in-flight ALU results are not tracked.
// CONFIGURATION
//  - `ALU_SCHED_PERF_EN` defined adds outputs:
//    perf_issue_cnt [NTHREADS][31:0]: per-thread granted issues.
//    perf_stall_cnt [NTHREADS][31:0]: cycles with req_valid & thread_en but no grant.
//    Both counters wrap, and both clear on rst.
//  - Undefined: ports absent, no counters synthesised; all other behaviour identical.
// STRUCTURE
//  - cpu_types: thread_id_t (logic[TID_W-1:0]), sched_state_t enum {SCHED_RUN, SCHED_BLOCKED}.
//  - cpu_config: NTHREADS default and BLK_TMO default.
//  - Sub-module rr_arbiter: NTHREADS-wide request vector + last pointer -> one-hot grant and encoded id.
//    Combinational; reusable for the LSU port.
// TESTING
//  1. Reset, all req_valid=4'b1111, no ctrl_flow:
//     grants cycle 0,1,2,3,0; issue_tid follows one cycle later.
//  2. T1 ctrl_flow grant: blocked=4'b0010 next cycle; T1 skipped.
//     done_valid/done_tid=1 -> T1 granted no earlier than the following cycle.
//  3. thread_en=4'b0101, all req_valid: grants alternate 0,2,0,2; T1 and T3 are never ready.
//  4. done_valid tid=3 while T3 is in RUN: sched_err=1 and stays 1; no state change.
//  5. T2 blocked, no done for BLK_TMO=15 cycles: sched_err rises on cycle 15; flush -> blocked=0.
//  6. flush in the same cycle as a ctrl_flow request: req_ready=0, no block, issue_valid=0 next cycle.
//     With ALU_SCHED_PERF_EN, the stall counter for that thread increments by 1.

Source files
------------

// File: rtl/alu_thread_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_thread_sched_pkg
// Brief   : Shared types and default configuration for the ALU thread
//           issue scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package alu_thread_sched_pkg;

    // Default configuration
    localparam int unsigned C_NTHREADS_DEF = 4;
    localparam int unsigned C_TID_W_DEF    = $clog2(C_NTHREADS_DEF);
    localparam int unsigned C_BLK_TMO_DEF  = 15;

    // Thread identifier at the default thread count
    typedef logic [C_TID_W_DEF-1:0] thread_id_t;

    // Per-thread scheduling state
    typedef enum logic {
        SCHED_RUN     = 1'b0,
        SCHED_BLOCKED = 1'b1
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_thread_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_thread_sched_if
// Brief   : Request/grant, ALU issue and ALU completion signals between the
//           per-thread decode stages, the scheduler and the ALU.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_thread_sched_if
    import alu_thread_sched_pkg::*;
#(
    parameter int unsigned NTHREADS = C_NTHREADS_DEF,
    parameter int unsigned TID_W    = $clog2(NTHREADS)
);
    logic [NTHREADS-1:0] req_valid;
    logic [NTHREADS-1:0] req_ctrl_flow;
    logic [NTHREADS-1:0] req_ready;
    logic                issue_valid;
    logic [TID_W-1:0]    issue_tid;
    logic                done_valid;
    logic [TID_W-1:0]    done_tid;

    // Decode stages and ALU side
    modport master (
        output req_valid, req_ctrl_flow, done_valid, done_tid,
        input  req_ready, issue_valid, issue_tid
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_ctrl_flow, done_valid, done_tid,
        output req_ready, issue_valid, issue_tid
    );
endinterface
`default_nettype wire

// File: rtl/alu_thread_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_thread_sched_rr_arbiter
// Brief   : Combinational round-robin arbiter. Searches the request vector
//           starting one above the last winner and returns a one-hot grant
//           plus the encoded winner id. N must be a power of two so the
//           search index wraps naturally in ID_W bits.
// Revision: 1.0 - initial release
// ============================================================================
module alu_thread_sched_rr_arbiter
    import alu_thread_sched_pkg::*;
#(
    parameter int unsigned N    = C_NTHREADS_DEF,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  wire logic [N-1:0]    i_req,
    input  wire logic [ID_W-1:0] i_last,
    output logic      [N-1:0]    o_gnt,
    output logic      [ID_W-1:0] o_gnt_id,
    output logic                 o_gnt_valid
);

    logic [ID_W-1:0] w_idx;

    // First requester found after i_last (wrapping) wins
    always_comb begin
        o_gnt       = '0;
        o_gnt_id    = '0;
        o_gnt_valid = 1'b0;
        w_idx       = '0;
        for (int k = 1; k <= int'(N); k++) begin
            w_idx = i_last + ID_W'(k);
            if (!o_gnt_valid && i_req[w_idx]) begin
                o_gnt_valid  = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_id     = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_thread_sched.sv
`default_nettype none
// ============================================================================
// Module  : alu_thread_sched
// Brief   : Issue scheduler sharing the single-cycle ALU between NTHREADS
//           hardware threads. Round-robin picks one eligible thread per
//           cycle; a thread issuing a branch/jump is blocked until the ALU
//           returns its new_pc. Blocked-too-long and spurious completions
//           raise a sticky sched_err.
//           Optional macro ALU_SCHED_PERF_EN adds per-thread issue/stall
//           counters as extra outputs.
// Revision: 1.0 - initial release
// ============================================================================
module alu_thread_sched
    import alu_thread_sched_pkg::*;
#(
    parameter int unsigned NTHREADS = C_NTHREADS_DEF,
    parameter int unsigned TID_W    = $clog2(NTHREADS),
    parameter int unsigned BLK_TMO  = C_BLK_TMO_DEF
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic [NTHREADS-1:0]      i_thread_en,
    input  wire logic                     i_flush,
    output logic      [NTHREADS-1:0]      o_blocked,
    output logic                          o_sched_err,
`ifdef ALU_SCHED_PERF_EN
    output logic [NTHREADS-1:0][31:0]     o_perf_issue_cnt,
    output logic [NTHREADS-1:0][31:0]     o_perf_stall_cnt,
`endif
    alu_thread_sched_if.slave             bus
);

    // Block-timeout counter width; kept at 1 when the check is disabled
    localparam int unsigned C_CNT_W = (BLK_TMO > 0) ? $clog2(BLK_TMO + 1) : 1;

    logic [NTHREADS-1:0] w_eligible;
    logic [NTHREADS-1:0] w_arb_req;
    logic [NTHREADS-1:0] w_gnt;
    logic [NTHREADS-1:0] w_err_evt;
    logic [TID_W-1:0]    w_gnt_id;
    logic                w_gnt_valid;

    logic                r_issue_valid;
    logic [TID_W-1:0]    r_issue_tid;
    logic [TID_W-1:0]    r_last_tid;
    logic                r_sched_err;

    assign w_eligible = i_thread_en & bus.req_valid & ~o_blocked;
    // A flush drops this cycle's grant; nothing is granted while in reset
    assign w_arb_req  = (rst || i_flush) ? '0 : w_eligible;

    alu_thread_sched_rr_arbiter #(
        .N    (NTHREADS),
        .ID_W (TID_W)
    ) u_arb (
        .i_req       (w_arb_req),
        .i_last      (r_last_tid),
        .o_gnt       (w_gnt),
        .o_gnt_id    (w_gnt_id),
        .o_gnt_valid (w_gnt_valid)
    );

    assign bus.req_ready   = w_gnt;
    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_tid   = r_issue_tid;
    assign o_sched_err     = r_sched_err;

    // ALU issue slot and round-robin pointer, one cycle after the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_valid <= 1'b0;
            r_issue_tid   <= '0;
            r_last_tid    <= TID_W'(NTHREADS - 1);
        end else if (w_gnt_valid) begin
            r_issue_valid <= 1'b1;
            r_issue_tid   <= w_gnt_id;
            r_last_tid    <= w_gnt_id;
        end else begin
            r_issue_valid <= 1'b0;
        end
    end

    // Sticky error flag collecting every per-thread error event
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sched_err <= 1'b0;
        end else if (|w_err_evt) begin
            r_sched_err <= 1'b1;
        end
    end

    for (genvar t = 0; t < int'(NTHREADS); t++) begin : g_thread
        sched_state_t r_state;
        sched_state_t w_state_nxt;
        logic         w_done_hit;
        logic         w_spurious;
        logic         w_tmo_evt;

        assign w_done_hit = bus.done_valid && (bus.done_tid == TID_W'(t));
        // A completion for a running thread is spurious unless a flush masks it
        assign w_spurious = w_done_hit && (r_state == SCHED_RUN) && !i_flush;

        // RUN/BLOCKED next-state: flush overrides everything
        always_comb begin
            w_state_nxt = r_state;
            if (i_flush) begin
                w_state_nxt = SCHED_RUN;
            end else begin
                case (r_state)
                    SCHED_RUN: begin
                        if (w_gnt[t] && bus.req_ctrl_flow[t]) begin
                            w_state_nxt = SCHED_BLOCKED;
                        end
                    end
                    SCHED_BLOCKED: begin
                        if (w_done_hit) begin
                            w_state_nxt = SCHED_RUN;
                        end
                    end
                    default: w_state_nxt = SCHED_RUN;
                endcase
            end
        end

        // Per-thread state register
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= SCHED_RUN;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        if (BLK_TMO > 0) begin : g_tmo
            localparam logic [C_CNT_W-1:0] C_CNT_MAX  = C_CNT_W'(BLK_TMO);
            localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(BLK_TMO - 1);
            logic [C_CNT_W-1:0] r_blk_cnt;

            // Count cycles spent BLOCKED, saturating at the timeout value
            always_ff @(posedge clk) begin
                if (rst || (r_state == SCHED_RUN)) begin
                    r_blk_cnt <= '0;
                end else if (r_blk_cnt != C_CNT_MAX) begin
                    r_blk_cnt <= r_blk_cnt + C_CNT_W'(1);
                end
            end

            // Fires once, on the edge the counter reaches the timeout,
            // unless the thread is released in that same cycle
            assign w_tmo_evt = (r_state == SCHED_BLOCKED) && (r_blk_cnt == C_CNT_LAST)
                               && !i_flush && !w_done_hit;
        end else begin : g_no_tmo
            assign w_tmo_evt = 1'b0;
        end

        assign w_err_evt[t] = w_spurious || w_tmo_evt;
        assign o_blocked[t] = (r_state == SCHED_BLOCKED);
    end

`ifdef ALU_SCHED_PERF_EN
    for (genvar p = 0; p < int'(NTHREADS); p++) begin : g_perf
        logic [31:0] r_issue_cnt;
        logic [31:0] r_stall_cnt;

        // Wrapping issue and stall counters
        always_ff @(posedge clk) begin
            if (rst) begin
                r_issue_cnt <= '0;
                r_stall_cnt <= '0;
            end else begin
                if (w_gnt[p]) begin
                    r_issue_cnt <= r_issue_cnt + 32'd1;
                end
                if (bus.req_valid[p] && i_thread_en[p] && !w_gnt[p]) begin
                    r_stall_cnt <= r_stall_cnt + 32'd1;
                end
            end
        end

        assign o_perf_issue_cnt[p] = r_issue_cnt;
        assign o_perf_stall_cnt[p] = r_stall_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_thread_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_thread_sched
// Brief   : Directed self-checking bench for alu_thread_sched (4 threads,
//           BLK_TMO=15). Honours ALU_SCHED_PERF_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_thread_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] thread_en;
    logic       flush;
    logic [3:0] blocked;
    logic       sched_err;
    int         checks   = 0;
    int         failures = 0;
`ifdef ALU_SCHED_PERF_EN
    logic [3:0][31:0] perf_issue;
    logic [3:0][31:0] perf_stall;
    logic [31:0]      stall_before;
`endif

    always #5 clk = ~clk;

    alu_thread_sched_if #(.NTHREADS(4), .TID_W(2)) bus ();

    alu_thread_sched #(
        .NTHREADS (4),
        .TID_W    (2),
        .BLK_TMO  (15)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_thread_en      (thread_en),
        .i_flush          (flush),
        .o_blocked        (blocked),
        .o_sched_err      (sched_err),
`ifdef ALU_SCHED_PERF_EN
        .o_perf_issue_cnt (perf_issue),
        .o_perf_stall_cnt (perf_stall),
`endif
        .bus              (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                = 1'b1;
        thread_en          = 4'hF;
        flush              = 1'b0;
        bus.req_valid      = 4'hF;
        bus.req_ctrl_flow  = 4'h0;
        bus.done_valid     = 1'b0;
        bus.done_tid       = 2'd0;
        tick();
        tick();

        // Reset state
        chk("rst_ready",       {28'd0, bus.req_ready}, 32'h0);
        chk("rst_issue_valid", {31'd0, bus.issue_valid}, 32'h0);
        chk("rst_issue_tid",   {30'd0, bus.issue_tid}, 32'h0);
        chk("rst_blocked",     {28'd0, blocked}, 32'h0);
        chk("rst_err",         {31'd0, sched_err}, 32'h0);

        // 1: round robin 0,1,2,3,0 with issue one cycle later
        rst = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("rr_ready", {28'd0, bus.req_ready}, 32'd1 << (i % 4));
            tick();
            chk("rr_issue_valid", {31'd0, bus.issue_valid}, 32'd1);
            chk("rr_issue_tid",   {30'd0, bus.issue_tid}, 32'(i % 4));
        end

        // 2: T1 control flow blocks until its done returns
        bus.req_ctrl_flow = 4'b0010;
        #1;
        chk("cf_ready", {28'd0, bus.req_ready}, 32'b0010);
        tick();
        bus.req_ctrl_flow = 4'b0000;
        #1;
        chk("cf_blocked",   {28'd0, blocked}, 32'b0010);
        chk("cf_issue_tid", {30'd0, bus.issue_tid}, 32'd1);
        chk("cf_ready_t2",  {28'd0, bus.req_ready}, 32'b0100);
        tick();
        chk("cf_ready_t3",  {28'd0, bus.req_ready}, 32'b1000);
        tick();
        chk("cf_skip_t1",   {28'd0, bus.req_ready}, 32'b0001);
        bus.done_valid = 1'b1;
        bus.done_tid   = 2'd1;
        #1;
        chk("cf_done_cycle_ready", {28'd0, bus.req_ready}, 32'b0001);
        chk("cf_done_cycle_blk",   {28'd0, blocked}, 32'b0010);
        tick();
        bus.done_valid = 1'b0;
        bus.done_tid   = 2'd0;
        #1;
        chk("cf_unblocked", {28'd0, blocked}, 32'b0000);
        chk("cf_regrant",   {28'd0, bus.req_ready}, 32'b0010);
        chk("cf_no_err",    {31'd0, sched_err}, 32'd0);
        tick();
        chk("cf_regrant_issue", {30'd0, bus.issue_tid}, 32'd1);

        // 3: only T0 and T2 enabled
        thread_en = 4'b0101;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("en_ready", {28'd0, bus.req_ready}, (i % 2 == 0) ? 32'b0100 : 32'b0001);
            tick();
            chk("en_issue_tid", {30'd0, bus.issue_tid}, (i % 2 == 0) ? 32'd2 : 32'd0);
        end
        thread_en = 4'hF;

        // 4: spurious done for running T3
        bus.done_valid = 1'b1;
        bus.done_tid   = 2'd3;
        #1;
        tick();
        bus.done_valid = 1'b0;
        bus.done_tid   = 2'd0;
        #1;
        chk("spur_err",     {31'd0, sched_err}, 32'd1);
        chk("spur_blocked", {28'd0, blocked}, 32'd0);
        tick();
        chk("spur_sticky",  {31'd0, sched_err}, 32'd1);

        // Mid-operation reset
        rst = 1'b1;
        #1;
        chk("rst2_ready", {28'd0, bus.req_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst2_err",         {31'd0, sched_err}, 32'd0);
        chk("rst2_issue_valid", {31'd0, bus.issue_valid}, 32'd0);

        // 5: T2 blocked with no done -> timeout after 15 cycles, flush clears
        bus.req_valid     = 4'b0100;
        bus.req_ctrl_flow = 4'b0100;
        #1;
        chk("tmo_ready", {28'd0, bus.req_ready}, 32'b0100);
        tick();
        bus.req_ctrl_flow = 4'b0000;
        #1;
        chk("tmo_blocked",       {28'd0, blocked}, 32'b0100);
        chk("tmo_blocked_ready", {28'd0, bus.req_ready}, 32'd0);
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        chk("tmo_err_before", {31'd0, sched_err}, 32'd0);
        tick();
        chk("tmo_err_rise",    {31'd0, sched_err}, 32'd1);
        chk("tmo_still_blk",   {28'd0, blocked}, 32'b0100);
        chk("tmo_issue_idle",  {31'd0, bus.issue_valid}, 32'd0);
        flush = 1'b1;
        #1;
        chk("flush_ready", {28'd0, bus.req_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_unblock", {28'd0, blocked}, 32'd0);
        chk("flush_err_kept", {31'd0, sched_err}, 32'd1);
        chk("flush_regrant", {28'd0, bus.req_ready}, 32'b0100);

        // 6: flush with a control-flow request in the same cycle
        bus.req_ctrl_flow = 4'b0100;
        flush             = 1'b1;
        #1;
        chk("fcf_ready", {28'd0, bus.req_ready}, 32'd0);
`ifdef ALU_SCHED_PERF_EN
        stall_before = perf_stall[2];
`endif
        tick();
        flush             = 1'b0;
        bus.req_ctrl_flow = 4'b0000;
        bus.req_valid     = 4'b0000;
        #1;
        chk("fcf_blocked",     {28'd0, blocked}, 32'd0);
        chk("fcf_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
`ifdef ALU_SCHED_PERF_EN
        chk("fcf_stall_cnt", perf_stall[2], stall_before + 32'd1);
`endif

        // No requests: no grant, idle issue slot
        chk("idle_ready", {28'd0, bus.req_ready}, 32'd0);
        tick();
        chk("idle_issue_valid", {31'd0, bus.issue_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
